// File: rtl/fifo_stream_adapter.sv
// Purpose: drains IN_WIDTH words from a shift-register FIFO and re-emits each one as RATIO narrow beats, LSB slice first.
// Latency: the first beat is valid 1 cycle after the pop edge. Throughput is 1 beat/cycle when POP_GAP < RATIO.
// Backpressure: while out_ready_i is low, out_data_o and out_last_o hold and no new pop is made. Optional out_last: FIFO_ADAPT_LAST_EN.
module fifo_stream_adapter #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int PKT_WORDS = 16,
  parameter int POP_GAP   = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic                 fifo_valid_i,
  input  logic [IN_WIDTH-1:0]  fifo_data_i,
  output logic                 fifo_enr_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic                 out_last_o,
  output logic                 busy_o
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int BW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
  localparam logic [1:0]    GAP_INIT  = 2'(POP_GAP);

  // Reject geometries the slicing and the 2-bit gap counter cannot represent.
  if ((IN_WIDTH % OUT_WIDTH) != 0 || PKT_WORDS < 1 || POP_GAP < 0 || POP_GAP > 3) begin : g_bad_cfg
    $error("fifo_stream_adapter: illegal parameter combination");
  end

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic [BW-1:0]                   beat_q, beat_d;
  logic [1:0]                      gap_q, gap_d;
  logic [IN_WIDTH-1:0]             hold_q, hold_d;
  logic [RATIO-1:0][OUT_WIDTH-1:0] slices;
  logic                            acc;
  logic                            lastb;
  logic                            pop;

  assign acc   = (state_q == ST_HOLD) & out_ready_i;
  assign lastb = acc & (beat_q == LAST_BEAT);
  // A pop may coincide with the last accepted beat, so back-to-back words leave no bubble.
  // Gating with the reset guarantees the FIFO never loses a word while the block is held in reset.
  assign pop   = rst_n_i & en_i & ~clear_i & fifo_valid_i & (gap_q == 2'd0) &
                 ((state_q == ST_EMPTY) | lastb);

  assign fifo_enr_o  = pop;
  assign out_valid_o = (state_q == ST_HOLD);
  assign slices      = hold_q;
  assign out_data_o  = slices[beat_q];
  assign busy_o      = (state_q == ST_HOLD) | (gap_q != 2'd0);

  // Next-state: clear dominates, then pop (loads a fresh word), then drain of the held word.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    if (clear_i) begin
      state_d = ST_EMPTY;
      beat_d  = '0;
      gap_d   = 2'd0;
    end else begin
      if (gap_q != 2'd0) begin
        gap_d = gap_q - 2'd1;
      end
      if (pop) begin
        hold_d  = fifo_data_i;
        state_d = ST_HOLD;
        beat_d  = '0;
        gap_d   = GAP_INIT;
      end else if (lastb) begin
        state_d = ST_EMPTY;
        beat_d  = '0;
      end else if (acc) begin
        beat_d = beat_q + BW'(1);
      end
    end
  end

  // Holding register, beat index and pop-gap counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
      beat_q  <= '0;
      gap_q   <= 2'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
    end
  end

`ifdef FIFO_ADAPT_LAST_EN
  localparam int WW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [WW-1:0] LAST_WORD = WW'(PKT_WORDS - 1);

  logic [WW-1:0] word_cnt_q, word_cnt_d;

  // Word position inside the packet advances on each completed word.
  always_comb begin
    word_cnt_d = word_cnt_q;
    if (clear_i) begin
      word_cnt_d = '0;
    end else if (lastb) begin
      word_cnt_d = (word_cnt_q == LAST_WORD) ? '0 : word_cnt_q + WW'(1);
    end
  end

  // Packet word counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign out_last_o = (state_q == ST_HOLD) & (beat_q == LAST_BEAT) & (word_cnt_q == LAST_WORD);
`else
  assign out_last_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: 32->8 bit, PKT_WORDS=2, POP_GAP=1, FIFO model with a registered valid.
// A queue model predicts every accepted beat and its out_last; directed vectors pin cycle timing.
// Inputs change 1-2 time units after posedge; outputs are sampled on negedge.
module tb_fifo_stream_adapter;

  localparam int RATIO = 4;
  localparam int PKT   = 2;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clear;
  logic        fifo_valid;
  logic [31:0] fifo_data;
  logic        fifo_enr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] fq[$];
  logic [7:0]  exp_q[$];
  int          words_popped = 0;
  int          beats_acc    = 0;
  int          pkt_beats    = 0;
  bit          enr_s        = 0;

  logic [7:0] t2 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  fifo_stream_adapter #(
    .IN_WIDTH (32),
    .OUT_WIDTH(8),
    .PKT_WORDS(PKT),
    .POP_GAP  (1)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .en_i        (en),
    .clear_i     (clear),
    .fifo_valid_i(fifo_valid),
    .fifo_data_i (fifo_data),
    .fifo_enr_o  (fifo_enr),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    for (int k = 0; k < RATIO; k++) exp_q.push_back(w[8*k +: 8]);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic bit exp_last(input int b);
`ifdef FIFO_ADAPT_LAST_EN
    return (b > 0) && (b % (RATIO * PKT) == 0);
`else
    return (b < 0);
`endif
  endfunction

  // FIFO model: pops on the strobe seen before the edge; valid is low for one cycle after each pop.
  initial begin
    bit popped;
    fifo_valid = 1'b0;
    fifo_data  = 32'h0;
    forever begin
      @(posedge clk);
      popped = enr_s;
      if (popped) begin
        if (fq.size() > 0) void'(fq.pop_front());
        words_popped++;
      end
      #2;
      fifo_valid = (fq.size() > 0) && !popped;
      fifo_data  = (fq.size() > 0) ? fq[0] : 32'h0;
    end
  end

  // Cycle-by-cycle comparison against the queue model.
  initial begin
    bit         pv_stall;
    logic [7:0] pv_data;
    logic       pv_last;
    bit         el;
    pv_stall = 1'b0;
    pv_data  = 8'h0;
    pv_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_enr", fifo_enr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_busy", busy, 0);
        pv_stall = 1'b0;
        enr_s    = 1'b0;
      end else begin
        chk("enr_without_valid", fifo_enr & ~fifo_valid, 0);
        chk("enr_during_clear", fifo_enr & clear, 0);
        if (!out_valid) chk("last_while_idle", out_last, 0);
        if (pv_stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, pv_data);
          chk("stall_last", out_last, pv_last);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h, required no beat at %0t", out_data, $time);
          end else begin
            chk("beat_data", out_data, exp_q.pop_front());
          end
`ifdef FIFO_ADAPT_LAST_EN
          el = (pkt_beats == RATIO * PKT - 1);
`else
          el = 1'b0;
`endif
          chk("beat_last", out_last, el);
          pkt_beats = (pkt_beats + 1) % (RATIO * PKT);
          beats_acc++;
        end
        if (clear) begin
          for (int k = beats_acc; k < words_popped * RATIO; k++)
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          beats_acc = words_popped * RATIO;
          pkt_beats = 0;
        end
        pv_stall = out_valid & ~out_ready & ~clear;
        pv_data  = out_data;
        pv_last  = out_last;
        enr_s    = fifo_enr;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    clear     = 1'b0;
    out_ready = 1'b1;
    push(32'hDDCCBBAA);

    // Reset with a word waiting in the FIFO: nothing pops.
    repeat (2) @(negedge clk);
    chk("reset_fifo_valid_seen", fifo_valid, 1);
    chk("reset_no_pop", fifo_enr, 0);
    nxt();
    rst_n = 1'b1;

    // Single word: pop now, four beats on the next four cycles.
    @(negedge clk);
    chk("t2_pop", fifo_enr, 1);
    chk("t2_idle_at_pop", out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_valid", out_valid, 1);
      chk("t2_data", out_data, t2[k]);
      if (k == 0) chk("t2_busy", busy, 1);
    end
    @(negedge clk);
    chk("t2_valid_drop", out_valid, 0);
    chk("t2_busy_idle", busy, 0);

    // Back-pressure on beat 1 with a second word already waiting.
    nxt();
    push(32'h44332211);
    push(32'h88776655);
    @(negedge clk);
    chk("t3_pop", fifo_enr, 1);
    @(negedge clk);
    chk("t3_beat0", out_data, 8'h11);
    nxt();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_data", out_data, 8'h22);
      chk("t3_no_pop", fifo_enr, 0);
    end
    nxt();
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_resume_beat1", out_data, 8'h22);
    @(negedge clk);
    chk("t3_beat2", out_data, 8'h33);
    @(negedge clk);
    chk("t3_beat3", out_data, 8'h44);
    chk("t3_pop_on_last", fifo_enr, 1);
    @(negedge clk);
    chk("t3_next_word", out_data, 8'h55);
    repeat (6) @(negedge clk);

    // Clear while idle realigns the packet counter.
    nxt();
    clear = 1'b1;
    nxt();
    clear = 1'b0;
    repeat (2) @(negedge clk);

    // Streaming: 8 words, 32 gapless beats, pops every 4th cycle.
    nxt();
    for (int j = 0; j < 8; j++) push(32'h40302010 + 32'(j) * 32'h01010101);
    for (int i = 0; i <= 33; i++) begin
      @(negedge clk);
      chk("t4_enr", fifo_enr, ((i % 4 == 0) && (i <= 28)) ? 1 : 0);
      chk("t4_valid", out_valid, ((i >= 1) && (i <= 32)) ? 1 : 0);
      chk("t4_last", out_last, (exp_last(i) && i <= 32) ? 1 : 0);
    end
    repeat (2) @(negedge clk);

    // Clear on beat 2 of the fifth word.
    nxt();
    for (int j = 0; j < 8; j++) push(32'hC0B0A090 + 32'(j) * 32'h01010101);
    for (int i = 0; i <= 33; i++) begin
      if (i > 0) nxt();
      clear = (i == 19);
      @(negedge clk);
      chk("t5_enr", fifo_enr, ((i % 4 == 0) && (i <= 28)) ? 1 : 0);
      chk("t5_valid", out_valid, (((i >= 1) && (i <= 19)) || ((i >= 21) && (i <= 32))) ? 1 : 0);
`ifdef FIFO_ADAPT_LAST_EN
      chk("t5_last", out_last, ((i == 8) || (i == 16) || (i == 28)) ? 1 : 0);
`else
      chk("t5_last", out_last, 0);
`endif
      if (i == 20) chk("t5_busy_after_clear", busy, 0);
    end
    repeat (2) @(negedge clk);

    // en low: the held word drains, no further pop until en returns.
    nxt();
    push(32'h0D0C0B0A);
    push(32'h1D1C1B1A);
    for (int i = 0; i <= 9; i++) begin
      if (i > 0) nxt();
      en = (i == 0) || (i >= 7);
      @(negedge clk);
      chk("t6_enr", fifo_enr, ((i == 0) || (i == 7)) ? 1 : 0);
      chk("t6_valid", out_valid, (((i >= 1) && (i <= 4)) || (i >= 8)) ? 1 : 0);
    end

    for (int k = 0; k < 40 && (exp_q.size() > 0 || out_valid); k++) @(negedge clk);
    chk("drain_model_empty", exp_q.size(), 0);
    chk("drain_fifo_empty", fq.size(), 0);
    chk("drain_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
